int_alu_shift_unit: RTL and testbench
=====================================

# int_alu_shift_unit

Single-issue integer ALU and barrel shifter with a registered result, used in the integer execution stage of the RSD back end. Each cycle it accepts one micro-op's operands and control codes. It evaluates either an arithmetic/logic operation or a shift, and presents the 32-bit result, the shifter carry-out and a valid flag one clock later. Branch, select and bypass logic sit outside this block.

## Interface
Clocking is decided: one clock; reset is asynchronous and active-low. The ports are named `clk` and `rst` as elsewhere in the codebase. `rst` asserted means low.

Parameters:
- `DATA_WIDTH`, default 32, operand and result width.
- `SHIFT_AMOUNT_BIT_SIZE`, default 5, shift-amount width; must equal log2(`DATA_WIDTH`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous reset, active low.
- `valid_in` in 1: the operands and controls on the other inputs are a real op this cycle.
- `op_is_shift` in 1: 0 selects the ALU result, 1 selects the shifter result.
- `alu_code` in 4: IntALU_Code.
- `op_a` in DATA_WIDTH: ALU/shifter operand A (the shift data).
- `op_b` in DATA_WIDTH: ALU operand B, and the register shift amount.
- `shift_operand_type` in 1: 0 = immediate amount, 1 = register amount.
- `shift_type` in 2: ShiftType.
- `imm_shift_amount` in SHIFT_AMOUNT_BIT_SIZE: immediate shift amount.
- `carry_in` in 1: carry returned when the shift amount is 0.
- `valid_out` out 1: registered `valid_in`.
- `data_out` out DATA_WIDTH: registered result.
- `carry_out` out 1: registered shifter carry.

## Operation
ALU codes (unsigned 32-bit arithmetic, wrap modulo 2^32):
- 0 ADD: a+b.
- 1 SUB: a−b.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SLT: signed a<b gives 1, else 0.
- 6 SLTU: unsigned a<b gives 1, else 0.
- 7 PASSB: b.
- Codes 8–15 give 0.

Shift amount:
- `shift_operand_type`=0 selects `imm_shift_amount`.
- `shift_operand_type`=1 selects `op_b[4:0]`.
- Upper bits of `op_b` are ignored.

Shift types:
- 0 SLL.
- 1 SRL: zero fill.
- 2 SRA: sign fill.
- 3 ROR: only with the macro, see Configuration.

Carry:
- Amount 0: result is `op_a` and carry equals `carry_in`.
- Amount n>0 with SLL: carry is bit 32−n of a.
- Amount n>0 with SRL, SRA or ROR: carry is bit n−1 of a.

Result selection:
- The result is the shifter output if `op_is_shift`=1, else the ALU output.
- With `op_is_shift`=0, the carry register captures 0.
- Control and data inputs are captured whatever `valid_in` is; downstream qualifies them with `valid_out`.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on outputs after edge k until edge k+1.
- Throughput: 1 op per cycle. There is no stall or handshake, and every cycle overwrites the registers.
- Reset: while `rst` is low, asynchronously, `valid_out`=0, `data_out`=0 and `carry_out`=0.
- Reset release: the first capture occurs at the first rising edge with `rst` high.
- Reset mid-stream: an op in flight is discarded, and its `valid_out` never asserts.
- All arithmetic is combinational ahead of the single register stage. There are no internal state machines.

## Configuration
- With `INT_ALU_ROTATE_EN` defined: shift_type 3 is a rotate-right by the selected amount, with carry as specified in Operation.
- Without the macro: shift_type 3 yields `data_out`=0 and `carry_out`=0. No rotate logic is synthesized.

## Structure
- Shared package (e.g. OpFormatTypes) holds:
  - IntALU_Code enum (4 bits, values above).
  - ShiftType enum (SLL/SRL/SRA/ROR).
  - ShiftOperandType enum (IMM/REG).
  - DATA_WIDTH and SHIFT_AMOUNT_BIT_SIZE constants.
- One natural sub-module, `int_barrel_shifter`: a combinational shifter with inputs a, amount, type and carry_in, and outputs result and carry.
- The ALU case statement, output mux and register stay in the top module.

## Test plan
- ADD wrap: a=0xFFFFFFFF, b=2, code 0 -> next cycle `data_out`=0x00000001, `valid_out`=1.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT gives 1, SLTU gives 0. SUB with a=5, b=7 gives 0xFFFFFFFE.
- Shifts via register amount: a=0x80000001, b=0x00000021 (amount 1):
  - SRA -> 0xC0000000, carry 1.
  - SLL -> 0x00000002, carry 1.
  - SRL -> 0x40000000, carry 1.
- Immediate amount 0, carry_in=1: a=0x1234 -> `data_out`=0x1234, `carry_out`=1.
- Shift type 3, amount 4, a=0x0000000F:
  - With the macro: 0xF0000000, carry 1.
  - Without the macro: 0, carry 0.
- Reset asserted mid-stream with valid ops:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first valid op appears one cycle after its input edge.

Source files
------------

// File: rtl/int_alu_shift_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_alu_shift_unit_pkg
// Purpose  : Shared operation-format types and width constants for the
//            integer ALU / barrel shifter execution unit.
// Revision : 1.0 - initial release
// ============================================================================
package int_alu_shift_unit_pkg;

    localparam int DATA_WIDTH_DEFAULT            = 32;
    localparam int SHIFT_AMOUNT_BIT_SIZE_DEFAULT = 5;

    // ALU operation codes; encodings 8-15 are unassigned and produce zero
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_PASSB = 4'd7
    } IntALU_Code;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } ShiftType;

    typedef enum logic {
        SHIFT_OPERAND_IMM = 1'b0,
        SHIFT_OPERAND_REG = 1'b1
    } ShiftOperandType;

endpackage
`default_nettype wire

// File: rtl/int_alu_shift_unit_shifter.sv
`default_nettype none
// ============================================================================
// Module   : int_barrel_shifter
// Purpose  : Combinational barrel shifter (SLL/SRL/SRA, optional ROR) with
//            shifter carry-out.
// Options  : INT_ALU_ROTATE_EN - enables rotate-right on shift type 3;
//            otherwise type 3 returns zero result and zero carry.
// Revision : 1.0 - initial release
// ============================================================================
module int_barrel_shifter
    import int_alu_shift_unit_pkg::*;
#(
    parameter int DATA_WIDTH            = DATA_WIDTH_DEFAULT,
    parameter int SHIFT_AMOUNT_BIT_SIZE = SHIFT_AMOUNT_BIT_SIZE_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0]            a,
    input  logic [SHIFT_AMOUNT_BIT_SIZE-1:0] amount,
    input  logic [1:0]                       shift_type,
    input  logic                             carry_in,
    output logic [DATA_WIDTH-1:0]            result,
    output logic                             carry
);

    localparam logic [SHIFT_AMOUNT_BIT_SIZE-1:0] C_ONE = SHIFT_AMOUNT_BIT_SIZE'(1);

    // Bit index of the last bit shifted out: left shifts lose bit W-n,
    // right shifts/rotates lose bit n-1. W-n is formed as the two's
    // complement of n, which is exact for n in 1..W-1.
    logic [SHIFT_AMOUNT_BIT_SIZE-1:0] w_left_idx;
    logic [SHIFT_AMOUNT_BIT_SIZE-1:0] w_right_idx;
    logic                             w_amount_zero;

    // Index helpers for the carry bit
    always_comb begin
        w_left_idx    = (~amount) + C_ONE;
        w_right_idx   = amount - C_ONE;
        w_amount_zero = (amount == '0);
    end

    // Shift datapath and carry selection
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (shift_type)
            SHIFT_SLL: begin
                result = a << amount;
                carry  = a[w_left_idx];
            end
            SHIFT_SRL: begin
                result = a >> amount;
                carry  = a[w_right_idx];
            end
            SHIFT_SRA: begin
                result = $signed(a) >>> amount;
                carry  = a[w_right_idx];
            end
            default: begin
`ifdef INT_ALU_ROTATE_EN
                // Left part uses W-n, valid because amount 0 is overridden below
                result = (a >> amount) | (a << w_left_idx);
                carry  = a[w_right_idx];
`else
                result = '0;
                carry  = 1'b0;
`endif
            end
        endcase
`ifdef INT_ALU_ROTATE_EN
        if (w_amount_zero) begin
`else
        // Without rotate support type 3 stays zero even for a zero amount
        if (w_amount_zero && (shift_type != SHIFT_ROR)) begin
`endif
            result = a;
            carry  = carry_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_alu_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : int_alu_shift_unit
// Purpose  : Single-issue integer ALU plus barrel shifter with one register
//            stage on result, shifter carry and valid.
// Options  : INT_ALU_ROTATE_EN - enables rotate-right (shift type 3).
// Revision : 1.0 - initial release
// ============================================================================
module int_alu_shift_unit
    import int_alu_shift_unit_pkg::*;
#(
    parameter int DATA_WIDTH            = DATA_WIDTH_DEFAULT,
    parameter int SHIFT_AMOUNT_BIT_SIZE = SHIFT_AMOUNT_BIT_SIZE_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic                             op_is_shift,
    input  logic [3:0]                       alu_code,
    input  logic [DATA_WIDTH-1:0]            op_a,
    input  logic [DATA_WIDTH-1:0]            op_b,
    input  logic                             shift_operand_type,
    input  logic [1:0]                       shift_type,
    input  logic [SHIFT_AMOUNT_BIT_SIZE-1:0] imm_shift_amount,
    input  logic                             carry_in,
    output logic                             valid_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             carry_out
);

    logic [DATA_WIDTH-1:0]            w_alu_result;
    logic [DATA_WIDTH-1:0]            w_shift_result;
    logic                             w_shift_carry;
    logic [SHIFT_AMOUNT_BIT_SIZE-1:0] w_shift_amount;

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;
    logic                  carry_d, carry_q;

    // Shift amount: immediate field or low bits of operand B
    always_comb begin
        w_shift_amount = (shift_operand_type == SHIFT_OPERAND_REG)
                       ? op_b[SHIFT_AMOUNT_BIT_SIZE-1:0]
                       : imm_shift_amount;
    end

    int_barrel_shifter #(
        .DATA_WIDTH            (DATA_WIDTH),
        .SHIFT_AMOUNT_BIT_SIZE (SHIFT_AMOUNT_BIT_SIZE)
    ) u_shifter (
        .a          (op_a),
        .amount     (w_shift_amount),
        .shift_type (shift_type),
        .carry_in   (carry_in),
        .result     (w_shift_result),
        .carry      (w_shift_carry)
    );

    // ALU operation decode; arithmetic wraps modulo 2^DATA_WIDTH
    always_comb begin
        w_alu_result = '0;
        case (alu_code)
            ALU_ADD:   w_alu_result = op_a + op_b;
            ALU_SUB:   w_alu_result = op_a - op_b;
            ALU_AND:   w_alu_result = op_a & op_b;
            ALU_OR:    w_alu_result = op_a | op_b;
            ALU_XOR:   w_alu_result = op_a ^ op_b;
            ALU_SLT:   w_alu_result = {{(DATA_WIDTH-1){1'b0}},
                                       ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: w_alu_result = op_b;
            default:   w_alu_result = '0;
        endcase
    end

    // Result mux; the carry is only meaningful for shift ops
    always_comb begin
        valid_d = valid_in;
        data_d  = op_is_shift ? w_shift_result : w_alu_result;
        carry_d = op_is_shift ? w_shift_carry  : 1'b0;
    end

    // Single output register stage, captured every cycle regardless of valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign carry_out = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_int_alu_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_alu_shift_unit
// Purpose  : Self-checking bench for int_alu_shift_unit with directed vectors,
//            randomized ops against a behavioural model, and reset scenarios.
// Options  : INT_ALU_ROTATE_EN - expectations follow the same macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_alu_shift_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        op_is_shift;
    logic [3:0]  alu_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        shift_operand_type;
    logic [1:0]  shift_type;
    logic [4:0]  imm_shift_amount;
    logic        carry_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    int_alu_shift_unit #(
        .DATA_WIDTH            (32),
        .SHIFT_AMOUNT_BIT_SIZE (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_in           (valid_in),
        .op_is_shift        (op_is_shift),
        .alu_code           (alu_code),
        .op_a               (op_a),
        .op_b               (op_b),
        .shift_operand_type (shift_operand_type),
        .shift_type         (shift_type),
        .imm_shift_amount   (imm_shift_amount),
        .carry_in           (carry_in),
        .valid_out          (valid_out),
        .data_out           (data_out),
        .carry_out          (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: returns {carry, data}
    function automatic logic [32:0] model(
        input logic sh, input logic [3:0] code,
        input logic [31:0] a, input logic [31:0] b,
        input logic sot, input logic [1:0] st,
        input logic [4:0] imm, input logic cin);
        int unsigned n;
        logic [63:0] wide;
        logic signed [63:0] swide;
        logic [31:0] d;
        logic c;
        d = 32'd0;
        c = 1'b0;
        if (!sh) begin
            case (code)
                4'd0: d = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
                4'd1: d = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
                4'd2: d = a & b;
                4'd3: d = a | b;
                4'd4: d = a ^ b;
                4'd5: d = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                4'd6: d = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
                4'd7: d = b;
                default: d = 32'd0;
            endcase
        end else begin
            n = sot ? (b % 32) : int'(imm);
`ifndef INT_ALU_ROTATE_EN
            if (st == 2'd3) begin
                d = 32'd0;
                c = 1'b0;
            end else
`endif
            if (n == 0) begin
                d = a;
                c = cin;
            end else begin
                case (st)
                    2'd0: begin
                        wide = {32'd0, a} << n;
                        d = wide[31:0];
                        c = wide[32];
                    end
                    2'd1: begin
                        wide = {a, 32'd0} >> n;
                        d = wide[63:32];
                        c = wide[31];
                    end
                    2'd2: begin
                        swide = $signed({a, 32'd0}) >>> n;
                        d = swide[63:32];
                        c = swide[31];
                    end
                    default: begin
                        wide = {a, a} >> n;
                        d = wide[31:0];
                        c = d[31];
                    end
                endcase
            end
        end
        return {c, d};
    endfunction

    task automatic drive(input logic v, input logic sh, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic sot, input logic [1:0] st,
                         input logic [4:0] imm, input logic cin);
        valid_in           = v;
        op_is_shift        = sh;
        alu_code           = code;
        op_a               = a;
        op_b               = b;
        shift_operand_type = sot;
        shift_type         = st;
        imm_shift_amount   = imm;
        carry_in           = cin;
    endtask

    typedef struct {
        logic        sh;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic        sot;
        logic [1:0]  st;
        logic [4:0]  imm;
        logic        cin;
        logic [31:0] exp_d;
        logic        exp_c;
        string       name;
    } vec_t;

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'd0, 32'h11, 32'h22, 1'b0, 2'd0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", data_out);
        end
        checks++;
        if (carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry: got %b want 0", carry_out);
        end
        #3 rst = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v[11];
        logic [31:0] ror_d;
        logic        ror_c;
`ifdef INT_ALU_ROTATE_EN
        ror_d = 32'hF000_0000;
        ror_c = 1'b1;
`else
        ror_d = 32'h0;
        ror_c = 1'b0;
`endif
        v[0]  = '{1'b0, 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'd0, 5'd0, 1'b0, 32'h1, 1'b0, "add_wrap"};
        v[1]  = '{1'b0, 4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 32'h1, 1'b0, "slt"};
        v[2]  = '{1'b0, 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, "sltu"};
        v[3]  = '{1'b0, 4'd1, 32'd5, 32'd7, 1'b0, 2'd0, 5'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub"};
        v[4]  = '{1'b1, 4'd0, 32'h8000_0001, 32'h21, 1'b1, 2'd2, 5'd9, 1'b0, 32'hC000_0000, 1'b1, "sra_reg"};
        v[5]  = '{1'b1, 4'd0, 32'h8000_0001, 32'h21, 1'b1, 2'd0, 5'd9, 1'b0, 32'h0000_0002, 1'b1, "sll_reg"};
        v[6]  = '{1'b1, 4'd0, 32'h8000_0001, 32'h21, 1'b1, 2'd1, 5'd9, 1'b0, 32'h4000_0000, 1'b1, "srl_reg"};
        v[7]  = '{1'b1, 4'd0, 32'h1234, 32'h5, 1'b0, 2'd0, 5'd0, 1'b1, 32'h1234, 1'b1, "imm_zero"};
        v[8]  = '{1'b1, 4'd0, 32'hF, 32'h0, 1'b0, 2'd3, 5'd4, 1'b0, ror_d, ror_c, "type3"};
        v[9]  = '{1'b0, 4'd9, 32'hAAAA, 32'h5555, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0, 1'b0, "code9"};
        v[10] = '{1'b0, 4'd7, 32'hAAAA, 32'hDEAD_BEEF, 1'b0, 2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, "passb"};
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, v[i].sh, v[i].code, v[i].a, v[i].b, v[i].sot, v[i].st, v[i].imm, v[i].cin);
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid: got %b want 1", v[i].name, valid_out);
            end
            checks++;
            if (data_out !== v[i].exp_d) begin
                errors++;
                $display("FAIL %s_data: got %h want %h", v[i].name, data_out, v[i].exp_d);
            end
            checks++;
            if (carry_out !== v[i].exp_c) begin
                errors++;
                $display("FAIL %s_carry: got %b want %b", v[i].name, carry_out, v[i].exp_c);
            end
        end
    endtask

    task automatic test_random();
        logic        v, sh, sot, cin;
        logic [3:0]  code;
        logic [31:0] a, b;
        logic [1:0]  st;
        logic [4:0]  imm;
        logic [32:0] exp;
        for (int i = 0; i < 400; i++) begin
            v    = 1'($urandom);
            sh   = 1'($urandom);
            code = 4'($urandom);
            sot  = 1'($urandom);
            st   = 2'($urandom);
            imm  = 5'($urandom);
            cin  = 1'($urandom);
            b    = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: a = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                3: a = 32'h0;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) b = a;
            exp = model(sh, code, a, b, sot, st, imm, cin);
            drive(v, sh, code, a, b, sot, st, imm, cin);
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== v) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b want %b", i, valid_out, v);
            end
            checks++;
            if (data_out !== exp[31:0]) begin
                errors++;
                $display("FAIL rand_data[%0d]: sh=%b code=%0d st=%0d a=%h b=%h got %h want %h",
                         i, sh, code, st, a, b, data_out, exp[31:0]);
            end
            checks++;
            if (carry_out !== exp[32]) begin
                errors++;
                $display("FAIL rand_carry[%0d]: sh=%b st=%0d a=%h got %b want %b",
                         i, sh, st, a, carry_out, exp[32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        for (int i = 0; i < 8; i++) begin
            exp = model(i[0], 4'd0, 32'h100 + 32'(i), 32'h1, 1'b1, 2'd0, 5'd0, 1'b0);
            drive(i[1], i[0], 4'd0, 32'h100 + 32'(i), 32'h1, 1'b1, 2'd0, 5'd0, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== i[1] || data_out !== exp[31:0] || carry_out !== exp[32]) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%b d=%h c=%b want v=%b d=%h c=%b",
                         i, valid_out, data_out, carry_out, i[1], exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b1, 4'd0, 32'h8000_0001, 32'h1, 1'b1, 2'd2, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hC000_0000 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got v=%b d=%h c=%b want v=1 d=c0000000 c=1",
                     valid_out, data_out, carry_out);
        end
        drive(1'b1, 1'b0, 4'd3, 32'hF0, 32'h0F, 1'b0, 2'd0, 5'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'd0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got v=%b d=%h c=%b want all 0",
                     valid_out, data_out, carry_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'd0) begin
            errors++;
            $display("FAIL mid_held: got v=%b d=%h want v=0 d=0", valid_out, data_out);
        end
        #3 rst = 1'b1;
        drive(1'b1, 1'b0, 4'd0, 32'h40, 32'h2, 1'b0, 2'd0, 5'd0, 1'b0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got v=%b want 0", valid_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h42 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_first: got v=%b d=%h c=%b want v=1 d=00000042 c=0",
                     valid_out, data_out, carry_out);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
